// File: rtl/dmem_responder.sv
// Data-memory responder: word array with configurable wait latency, byte-lane stores, error reporting.
// Optional macro DMEM_RMW_EN: partial stores take an extra read-modify-write cycle instead of a masked write.
module dmem_responder #(
    parameter int NB_WORD     = 32,
    parameter int NB_ADDR     = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_dmem_req,
    input  logic               i_dmem_wr_enable,
    input  logic [NB_ADDR-1:0] i_dmem_address,
    input  logic [NB_WORD-1:0] i_dmem_wr_data,
    input  logic [3:0]         i_dmem_be,
    output logic [NB_WORD-1:0] o_dmem_rd_data,
    output logic               o_dmem_ack,
    output logic               o_dmem_busy,
    output logic               o_dmem_err
);
    localparam int NB_IDX = $clog2(DEPTH_WORDS);
`ifdef DMEM_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RMW, SERVE} state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_wr;
    logic               r_err;
    logic               r_partial;
    logic [NB_IDX-1:0]  r_idx;
    logic [NB_WORD-1:0] r_wdata;
    logic [NB_WORD-1:0] r_merge;
    logic [3:0]         r_be;
    logic [NB_WORD-1:0] r_mem [DEPTH_WORDS];

    logic [NB_IDX-1:0]  w_idx;
    logic               w_err;
    logic               w_partial;
    logic [NB_WORD-1:0] w_merged;

    assign w_idx     = i_dmem_address[NB_IDX+1:2];
    assign w_err     = (i_dmem_address[1:0] != 2'b00) ||
                       ((i_dmem_address >> (NB_IDX + 2)) != '0);
    // Only the RMW build routes partial stores through the merge state; errored requests never do.
    assign w_partial = RMW_EN && i_dmem_wr_enable && !w_err &&
                       (i_dmem_be != 4'b0000) && (i_dmem_be != 4'b1111);

    always_comb begin
        w_merged = r_merge;
        for (int k = 0; k < 4; k++)
            if (r_be[k]) w_merged[8*k +: 8] = r_wdata[8*k +: 8];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            o_dmem_rd_data <= '0;
            o_dmem_ack     <= 1'b0;
            o_dmem_busy    <= 1'b0;
            o_dmem_err     <= 1'b0;
        end else begin
            o_dmem_ack <= 1'b0;
            o_dmem_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_dmem_req) begin
                        r_wr        <= i_dmem_wr_enable;
                        r_idx       <= w_idx;
                        r_wdata     <= i_dmem_wr_data;
                        r_be        <= i_dmem_be;
                        r_err       <= w_err;
                        r_partial   <= w_partial;
                        r_cnt       <= 4'(LATENCY);
                        o_dmem_busy <= 1'b1;
                        if (LATENCY != 0) begin
                            r_state <= WAIT;
                        end else if (w_partial) begin
                            r_state <= RMW;
                        end else begin
                            r_state    <= SERVE;
                            o_dmem_ack <= 1'b1;
                            o_dmem_err <= w_err;
                            if (!i_dmem_wr_enable)
                                o_dmem_rd_data <= w_err ? '0 : r_mem[w_idx];
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        if (r_partial) begin
                            r_state <= RMW;
                        end else begin
                            r_state    <= SERVE;
                            o_dmem_ack <= 1'b1;
                            o_dmem_err <= r_err;
                            if (!r_wr)
                                o_dmem_rd_data <= r_err ? '0 : r_mem[r_idx];
                        end
                    end
                end
                RMW: begin
                    r_merge    <= r_mem[r_idx];
                    r_state    <= SERVE;
                    o_dmem_ack <= 1'b1;
                end
                SERVE: begin
                    r_state     <= IDLE;
                    o_dmem_busy <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Store commits at the end of the ack cycle, so a reset before then leaves the array untouched.
    always_ff @(posedge i_clock) begin
        if (!i_reset && r_state == SERVE && r_wr && !r_err) begin
            if (RMW_EN) begin
                if (r_be != 4'b0000) r_mem[r_idx] <= w_merged;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (r_be[k]) r_mem[r_idx][8*k +: 8] <= r_wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024); honours DMEM_RMW_EN for partial-store latency.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd_data;
    logic        ack;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_RMW_EN
    localparam int PART_LAT = 4;
`else
    localparam int PART_LAT = 3;
`endif

    dmem_responder #(.NB_WORD(32), .NB_ADDR(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_dmem_req       (req),
        .i_dmem_wr_enable (wr_en),
        .i_dmem_address   (addr),
        .i_dmem_wr_data   (wdata),
        .i_dmem_be        (be),
        .o_dmem_rd_data   (rd_data),
        .o_dmem_ack       (ack),
        .o_dmem_busy      (busy),
        .o_dmem_err       (err)
    );

    always #5 clk = ~clk;

    // One request: n = edges from acceptance edge through the edge that raised ack.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int n, output logic [31:0] rd,
                        output logic e, output int nbusy);
        @(negedge clk);
        req = 1'b1; wr_en = w; addr = a; wdata = d; be = b;
        n = 0; nbusy = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (busy) nbusy++;
        end while (!ack && n < 50);
        rd = rd_data;
        e  = err;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read;
        int n, nb; logic [31:0] rd; logic e;
        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, n, rd, e, nb);
        checks++; if (n !== 3) begin errors++; $display("FAIL preload_lat got=%0d exp=3", n); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, n, rd, e, nb);
        checks++; if (n !== 3) begin errors++; $display("FAIL read_lat got=%0d exp=3", n); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data got=%h exp=deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", e); end
        checks++; if (nb !== 3) begin errors++; $display("FAIL read_busy_cycles got=%0d exp=3", nb); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || ack !== 1'b0) begin
            errors++; $display("FAIL read_idle_after busy=%b ack=%b exp=0/0", busy, ack); end
    endtask

    task automatic test_full_write;
        int n, nb; logic [31:0] rd; logic e;
        xact(1'b1, 32'h20, 32'h1234_5678, 4'hF, n, rd, e, nb);
        checks++; if (n !== 3) begin errors++; $display("FAIL wr_lat got=%0d exp=3", n); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_hold got=%h exp=deadbeef", rd); end
        xact(1'b0, 32'h20, 32'h0, 4'h0, n, rd, e, nb);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL wr_readback got=%h exp=12345678", rd); end
    endtask

    task automatic test_partial_write;
        int n, nb; logic [31:0] rd; logic e;
        xact(1'b1, 32'h20, 32'h0000_AB00, 4'b0010, n, rd, e, nb);
        checks++; if (n !== PART_LAT) begin errors++; $display("FAIL part_lat got=%0d exp=%0d", n, PART_LAT); end
        xact(1'b0, 32'h20, 32'h0, 4'h0, n, rd, e, nb);
        checks++; if (rd !== 32'h1234_AB78) begin errors++; $display("FAIL part_readback got=%h exp=1234ab78", rd); end
        xact(1'b1, 32'h20, 32'hAA00_00BB, 4'b1001, n, rd, e, nb);
        xact(1'b0, 32'h20, 32'h0, 4'h0, n, rd, e, nb);
        checks++; if (rd !== 32'hAA34_ABBB) begin errors++; $display("FAIL part2_readback got=%h exp=aa34abbb", rd); end
        xact(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, n, rd, e, nb);
        checks++; if (n !== 3) begin errors++; $display("FAIL be0_lat got=%0d exp=3", n); end
        xact(1'b0, 32'h20, 32'h0, 4'h0, n, rd, e, nb);
        checks++; if (rd !== 32'hAA34_ABBB) begin errors++; $display("FAIL be0_readback got=%h exp=aa34abbb", rd); end
    endtask

    task automatic test_errors;
        int n, nb; logic [31:0] rd; logic e;
        xact(1'b0, 32'h0000_0002, 32'h0, 4'h0, n, rd, e, nb);
        checks++; if (n !== 3 || e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL misalign_rd lat=%0d err=%b rd=%h exp=3/1/0", n, e, rd); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_after_ack got=%b exp=0", err); end
        xact(1'b0, 32'h0000_1000, 32'h0, 4'h0, n, rd, e, nb);
        checks++; if (n !== 3 || e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL oor_rd lat=%0d err=%b rd=%h exp=3/1/0", n, e, rd); end
        xact(1'b1, 32'h0000_0022, 32'h5555_5555, 4'b0010, n, rd, e, nb);
        checks++; if (n !== 3 || e !== 1'b1) begin
            errors++; $display("FAIL misalign_wr lat=%0d err=%b exp=3/1", n, e); end
        xact(1'b1, 32'h0000_1020, 32'h5555_5555, 4'hF, n, rd, e, nb);
        xact(1'b0, 32'h20, 32'h0, 4'h0, n, rd, e, nb);
        checks++; if (rd !== 32'hAA34_ABBB || e !== 1'b0) begin
            errors++; $display("FAIL err_no_write rd=%h err=%b exp=aa34abbb/0", rd, e); end
    endtask

    task automatic test_back_to_back;
        int n, nb; logic [31:0] rd; logic e;
        int cyc, nack, last;
        logic [31:0] exp_rd;
        xact(1'b1, 32'h30, 32'hAAAA_0030, 4'hF, n, rd, e, nb);
        xact(1'b1, 32'h34, 32'hBBBB_0034, 4'hF, n, rd, e, nb);
        @(negedge clk);
        req = 1'b1; wr_en = 1'b0; addr = 32'h30; be = 4'h0;
        cyc = 0; nack = 0; last = -1;
        repeat (20) begin
            @(posedge clk); #1;
            cyc++;
            if (ack) begin
                exp_rd = (nack % 2 == 0) ? 32'hAAAA_0030 : 32'hBBBB_0034;
                checks++; if (rd_data !== exp_rd) begin
                    errors++; $display("FAIL b2b_data ack=%0d got=%h exp=%h", nack, rd_data, exp_rd); end
                checks++; if (cyc !== ((last < 0) ? 3 : last + 4)) begin
                    errors++; $display("FAIL b2b_spacing ack=%0d at=%0d prev=%0d", nack, cyc, last); end
                last = cyc;
                nack++;
                addr = (addr == 32'h30) ? 32'h34 : 32'h30;
            end
        end
        checks++; if (nack !== 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", nack); end
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_abort;
        int n, nb; logic [31:0] rd; logic e;
        xact(1'b1, 32'h40, 32'h1111_1111, 4'hF, n, rd, e, nb);
        @(negedge clk);
        req = 1'b1; wr_en = 1'b1; addr = 32'h40; wdata = 32'h2222_2222; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || ack !== 1'b0) begin
            errors++; $display("FAIL abort_outputs busy=%b ack=%b exp=0/0", busy, ack); end
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'h40, 32'h0, 4'h0, n, rd, e, nb);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL abort_readback got=%h exp=11111111", rd); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_full_write();
        test_partial_write();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
